// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vec_pkg
//  Description : Shared widths, register-file constants and the load-engine
//                state encoding for the vector load unit and its interface.
//                All widths of the slice are configured here; the number of
//                words per vector is derived and is not set independently.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

    localparam int WORD_W = 32;                  // memory data word width
    localparam int VEC_W  = 256;                 // vector register width
    localparam int ADDR_W = 32;                  // byte-address width
    localparam int NWORDS = VEC_W / WORD_W;      // words per vector
    localparam int IDX_W  = $clog2(NWORDS);      // word index width

    localparam int         NUM_VREGS    = 3;     // vector registers present
    localparam logic [1:0] VREG_INVALID = 2'b11; // the one unused RW code

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vload_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface   : vload_unit_if
//  Description : Bus bundle of the vector load unit.
//                Memory read port : mem_req, mem_addr -> ; <- mem_gnt,
//                                   mem_rdata, mem_rvalid
//                Reg-file write   : reg_write (RegWrite), reg_rw (RW),
//                                   reg_busw (busW)
//                master = load unit side, slave = memory / register-file side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vload_unit_if import vec_pkg::*; ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_rvalid;

    logic              reg_write;
    logic [1:0]        reg_rw;
    logic [VEC_W-1:0]  reg_busw;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rdata, mem_rvalid,
        output reg_write, reg_rw, reg_busw
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rdata, mem_rvalid,
        input  reg_write, reg_rw, reg_busw
    );

endinterface
`default_nettype wire

// File: rtl/vload_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vload_unit
//  Description : Vector load engine. On an accepted start it reads NWORDS
//                consecutive words from data memory (one request outstanding
//                at a time), assembles them into one VEC_W-bit vector (word 0
//                in the low lane) and writes it to the selected vector
//                register with a single-cycle reg_write pulse.
//  Ports       : clk, reset (async, active-high)
//                start, base_addr, dest_reg  - load request from ID/EX
//                busy, done, err             - status back to the control path
//                bus (vload_unit_if.master)  - memory read port + RF write port
//  Revision    : 1.0 - initial release
// ============================================================================
module vload_unit import vec_pkg::*; (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [1:0]        dest_reg,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    vload_unit_if.master           bus
);

    // ------------------------------------------------------------------------
    // Elaboration guard: the vector must split into a whole number of words,
    // and the index counter needs at least one bit.
    // ------------------------------------------------------------------------
    if ((VEC_W % WORD_W) != 0 || NWORDS < 2) begin : g_width_check
        $error("vload_unit: VEC_W must be a multiple (>=2x) of WORD_W");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [ADDR_W-1:0]  r_base;
    logic [1:0]         r_dest;
    logic [VEC_W-1:0]   r_buf;

    logic               w_start_ok;
    logic               w_last;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [ADDR_W-1:0]  w_next_addr;
    logic [VEC_W-1:0]   w_buf_next;

    // A request is only taken for an existing register and a word-aligned base.
    assign w_start_ok  = (int'(dest_reg) < NUM_VREGS) && (dest_reg != VREG_INVALID)
                         && (base_addr[1:0] == 2'b00);
    assign w_last      = (r_idx == IDX_W'(NWORDS - 1));
    assign w_idx_inc   = r_idx + IDX_W'(1);
    // Address arithmetic is modulo 2^ADDR_W; a vector may straddle the top.
    assign w_next_addr = r_base + (ADDR_W'(w_idx_inc) << 2);

    // Buffer with the current word merged into its lane; also feeds busW so
    // the last word does not need an extra cycle to reach the write port.
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[WORD_W*int'(r_idx) +: WORD_W] = bus.mem_rdata;
    end

    // ------------------------------------------------------------------------
    // Control FSM. Every output is a flop so the register file and memory see
    // clean, glitch-free strobes; mem_addr is loaded on entry to REQ and is
    // therefore stable for the whole request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_base        <= '0;
            r_dest        <= '0;
            r_buf         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.reg_write <= 1'b0;
            bus.reg_rw    <= '0;
            bus.reg_busw  <= '0;
        end else begin
            // Pulse outputs default low; reg_rw/reg_busw hold their value.
            done          <= 1'b0;
            err           <= 1'b0;
            bus.reg_write <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_base       <= base_addr;
                            r_dest       <= dest_reg;
                            r_idx        <= '0;
                            busy         <= 1'b1;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= base_addr;
                            r_state      <= ST_REQ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        r_state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.mem_rvalid) begin
                        r_buf <= w_buf_next;
                        if (w_last) begin
                            bus.reg_write <= 1'b1;
                            bus.reg_rw    <= r_dest;
                            bus.reg_busw  <= w_buf_next;
                            done          <= 1'b1;
                            r_state       <= ST_WRITE;
                        end else begin
                            r_idx        <= w_idx_inc;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= w_next_addr;
                            r_state      <= ST_REQ;
                        end
                    end
                end

                ST_WRITE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/vload_unit.md
Name: vload_unit

Overview:
- Vector load engine that produces the write side of the 3-entry × 256-bit vector register file.
- Fetches VEC_W/WORD_W consecutive 32-bit words from data memory and assembles them into one 256-bit vector.
- Writes the vector into the selected vector register with a single-cycle reg_write pulse (RW/RegWrite/busW convention).
- Sits between the ID/EX control path, which issues the start, and the data-memory read port.

Parameters:
- WORD_W, 32, memory data word width in bits.
- VEC_W, 256, vector width in bits; must be an integer multiple of WORD_W.
- ADDR_W, 32, byte-address width.
- NWORDS, VEC_W/WORD_W (8), derived; words per vector. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- base_addr  in  ADDR_W  byte address of word 0; latched on accepted start.
- dest_reg  in  2  destination vector register; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, coincident with reg_write.
- err  out  1  one-cycle pulse when a start is rejected.
- mem_req  out  1  read request; held until granted.
- mem_addr  out  ADDR_W  word byte address; stable while mem_req is high.
- mem_gnt  in  1  request accepted this cycle.
- mem_rdata  in  WORD_W  read data.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- reg_write  out  1  register-file write enable (RegWrite).
- reg_rw  out  2  register-file write address (RW).
- reg_busw  out  VEC_W  register-file write data (busW).

Behaviour:
- Reset: async; state=IDLE, idx=0, data buffer=0. All outputs are 0, including reg_busw and mem_addr.
- States:
  - IDLE: start && dest_reg<3 && base_addr[1:0]==0 → latch base/dest, idx=0, go to REQ. Otherwise stay.
  - REQ: mem_req=1, mem_addr=base+4*idx (modulo 2^ADDR_W, wraps silently). mem_gnt → WAIT.
  - WAIT: on mem_rvalid, write buffer[WORD_W*idx +: WORD_W]=mem_rdata. If idx==NWORDS-1 → WRITE, else idx++ and go to REQ.
  - WRITE: reg_write=1, done=1, reg_rw=latched dest, reg_busw=buffer for exactly one cycle; → IDLE.
- Lane order: word 0 (lowest address) lands in bits [31:0]; word 7 lands in [255:224].
- Only one request is outstanding at a time. mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.
- Latency with zero-wait memory (gnt in REQ cycle, rvalid in the first WAIT cycle): 2 cycles per word. With start accepted at edge N, reg_write is high in cycle N+17. Each stall cycle adds 1.
- Rejection: start with dest_reg==2'b11 or a misaligned base_addr → err=1 in the next cycle, no memory traffic, stay in IDLE.
- start while busy is ignored; no queuing, no err.
- reg_rw and reg_busw are meaningful only while reg_write is high. Outside WRITE they hold their last values (0 after reset).
- Reset mid-operation: immediate return to IDLE. No reg_write is issued; partial buffer contents are discarded (cleared).
- err and done are never high in the same cycle.

Decomposition:
- Shared package vec_pkg: VEC_W, WORD_W, NUM_VREGS=3, VREG_INVALID=2'b11, and the state encoding (IDLE, REQ, WAIT, WRITE).
- No sub-module. FSM, index counter, address adder and data buffer fit in one module.

Test Plan:
- Zero-wait memory returning word k = 32'h1000_0000+k; start, base=0x100, dest=1 → mem_addr sequence 0x100..0x11C. reg_write at cycle N+17 with reg_rw=1 and reg_busw={32'h1000_0007,…,32'h1000_0000}, done coincident.
- mem_gnt delayed 3 cycles on word 2, mem_rvalid delayed 2 cycles on word 5 → mem_addr stable during the stall, reg_write at N+22, data identical to the zero-wait case.
- start with dest_reg=3, then with base=0x102 → err pulses once per attempt, mem_req stays 0, busy stays 0, no reg_write.
- base=0xFFFF_FFF0 → addresses 0xFFFF_FFF0,…,0xFFFF_FFFC,0x0,…,0xC.
- Assert reset after word 4 is captured → busy, mem_req, reg_write and reg_busw drop to 0 asynchronously. A subsequent start with dest=0 writes a clean vector.
- start pulsed while busy, plus a spurious mem_rvalid in REQ → both ignored, exactly one reg_write with the expected data.
